// File: rtl/mode3_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mode3_pkg
//  Purpose  : Shared widths, constants and FSM state type for mode3_decode.
//  Contents : VAL_W/ROOT_W/OP_W/K_W widths, root search bounds, state_t enum.
//  Revision : 1.0  initial release
// ============================================================================
package mode3_pkg;

    localparam int VAL_W  = 12;   // packed input value width
    localparam int ROOT_W = 4;    // cube-root candidate width
    localparam int OP_W   = 3;    // recovered operand width
    localparam int K_W    = 2 * OP_W;  // pair scan index {a,b}

    // Root search starts at the largest 4-bit candidate and walks down.
    localparam logic [ROOT_W-1:0] ROOT_START    = 4'd15;
    // Roots above this cannot be matched: 7^2+7^2 = 98 < 10^2.
    localparam logic [ROOT_W-1:0] PAIR_MAX_ROOT = 4'd9;
    localparam logic [K_W-1:0]    K_LAST        = 6'd63;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ROOT = 2'd1,
        S_PAIR = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage : mode3_pkg
`default_nettype wire

// File: rtl/mode3_cand_eval.sv
`default_nettype none
// ============================================================================
//  Module   : mode3_cand_eval
//  Purpose  : Combinational evaluation of one search candidate.
//  Ports    : r_i      - root candidate
//             a_i,b_i  - pair candidate operands
//             value_i  - captured value
//             cube_le_o    - r^3 <= value (12-bit arithmetic)
//             cube_eq_o    - r^3 == value
//             pair_match_o - r^2 <= a^2+b^2 < (r+1)^2 (7-bit arithmetic)
//  Revision : 1.0  initial release
// ============================================================================
module mode3_cand_eval
    import mode3_pkg::*;
(
    input  logic [ROOT_W-1:0] r_i,
    input  logic [OP_W-1:0]   a_i,
    input  logic [OP_W-1:0]   b_i,
    input  logic [VAL_W-1:0]  value_i,
    output logic              cube_le_o,
    output logic              cube_eq_o,
    output logic              pair_match_o
);

    logic [VAL_W-1:0] w_r12;
    logic [VAL_W-1:0] w_cube;
    logic [6:0]       w_r7;
    logic [6:0]       w_r1;
    logic [6:0]       w_a7;
    logic [6:0]       w_b7;
    logic [6:0]       w_rsq;
    logic [6:0]       w_r1sq;
    logic [6:0]       w_absum;

    // 15^3 = 3375 still fits in 12 bits, so no candidate wraps.
    assign w_r12  = {{(VAL_W-ROOT_W){1'b0}}, r_i};
    assign w_cube = w_r12 * w_r12 * w_r12;

    assign cube_le_o = (w_cube <= value_i);
    assign cube_eq_o = (w_cube == value_i);

    // Pair test is only consumed for r <= 9, where (r+1)^2 <= 100 fits 7 bits.
    assign w_r7    = {3'b000, r_i};
    assign w_r1    = w_r7 + 7'd1;
    assign w_a7    = {4'b0000, a_i};
    assign w_b7    = {4'b0000, b_i};
    assign w_rsq   = w_r7 * w_r7;
    assign w_r1sq  = w_r1 * w_r1;
    assign w_absum = (w_a7 * w_a7) + (w_b7 * w_b7);

    assign pair_match_o = (w_rsq <= w_absum) && (w_absum < w_r1sq);

endmodule : mode3_cand_eval
`default_nettype wire

// File: rtl/mode3_decode.sv
`default_nettype none
// ============================================================================
//  Module   : mode3_decode
//  Purpose  : Sequential decoder of a mode3 out_8x value: finds the floor cube
//             root r by descending search, then scans (a,b) pairs for the
//             first one with r^2 <= a^2+b^2 < (r+1)^2.
//  Ports    : clk, rst (sync, active high)
//             in_valid/in_ready/in_val   - request handshake and value
//             out_valid/out_ready        - result handshake
//             root, exact, pair_found, a_out, b_out - registered result
//  Revision : 1.0  initial release
// ============================================================================
module mode3_decode
    import mode3_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [VAL_W-1:0]  in_val,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ROOT_W-1:0] root,
    output logic              exact,
    output logic              pair_found,
    output logic [OP_W-1:0]   a_out,
    output logic [OP_W-1:0]   b_out
);

    state_t            state_q, state_d;
    logic [VAL_W-1:0]  val_q,   val_d;
    logic [ROOT_W-1:0] r_q,     r_d;
    logic [K_W-1:0]    k_q,     k_d;
    logic [ROOT_W-1:0] root_q,  root_d;
    logic              exact_q, exact_d;
    logic              pf_q,    pf_d;
    logic [OP_W-1:0]   a_q,     a_d;
    logic [OP_W-1:0]   b_q,     b_d;

    logic              w_cube_le;
    logic              w_cube_eq;
    logic              w_pair_match;

    // Pair operands come straight from the scan index: k = {a, b}.
    mode3_cand_eval u_cand_eval (
        .r_i          (r_q),
        .a_i          (k_q[K_W-1:OP_W]),
        .b_i          (k_q[OP_W-1:0]),
        .value_i      (val_q),
        .cube_le_o    (w_cube_le),
        .cube_eq_o    (w_cube_eq),
        .pair_match_o (w_pair_match)
    );

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        r_d     = r_q;
        k_d     = k_q;
        root_d  = root_q;
        exact_d = exact_q;
        pf_d    = pf_q;
        a_d     = a_q;
        b_d     = b_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    val_d   = in_val;
                    r_d     = ROOT_START;
                    state_d = S_ROOT;
                end
            end

            S_ROOT: begin
                // r = 0 always satisfies the test, so the walk cannot underflow.
                if (w_cube_le) begin
                    root_d  = r_q;
                    exact_d = w_cube_eq;
                    if (r_q > PAIR_MAX_ROOT) begin
                        pf_d    = 1'b0;
                        a_d     = '0;
                        b_d     = '0;
                        state_d = S_DONE;
                    end else begin
                        k_d     = '0;
                        state_d = S_PAIR;
                    end
                end else begin
                    r_d = r_q - 4'd1;
                end
            end

            S_PAIR: begin
                if (w_pair_match) begin
                    pf_d    = 1'b1;
                    a_d     = k_q[K_W-1:OP_W];
                    b_d     = k_q[OP_W-1:0];
                    state_d = S_DONE;
                end else if (k_q == K_LAST) begin
                    pf_d    = 1'b0;
                    a_d     = '0;
                    b_d     = '0;
                    state_d = S_DONE;
                end else begin
                    k_d = k_q + 6'd1;
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            val_q   <= '0;
            r_q     <= '0;
            k_q     <= '0;
            root_q  <= '0;
            exact_q <= 1'b0;
            pf_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            r_q     <= r_d;
            k_q     <= k_d;
            root_q  <= root_d;
            exact_q <= exact_d;
            pf_q    <= pf_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign root       = root_q;
    assign exact      = exact_q;
    assign pair_found = pf_q;
    assign a_out      = a_q;
    assign b_out      = b_q;

endmodule : mode3_decode
`default_nettype wire

// File: doc/mode3_decode.md
MODE3_DECODE -- requirements
Module: mode3_decode

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port in_valid, input, 1, request strobe.
REQ-004 SHALL have port in_ready, output, 1, block can accept a request.
REQ-005 SHALL have port in_val, input, 12, value in mode3 out_8x format (unsigned).
REQ-006 SHALL have port out_valid, output, 1, result available.
REQ-007 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-008 SHALL have port root, output, 4, floor cube root of in_val.
REQ-009 SHALL have port exact, output, 1, root^3 == in_val.
REQ-010 SHALL have port pair_found, output, 1, an (a,b) pair was found.
REQ-011 SHALL have port a_out, output, 3, recovered a operand.
REQ-012 SHALL have port b_out, output, 3, recovered b operand.

Function
REQ-013 SHALL implement FSM states IDLE, ROOT, PAIR, DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE; acceptance = in_valid & in_ready; in_val is captured in a register on acceptance; next state is ROOT.
REQ-015 In ROOT, SHALL test one candidate r per cycle, starting at 15 and descending; it stops at the first r with r^3 <= captured value, so ROOT spends 16-r cycles.
REQ-016 SHALL latch root=r and exact=(r^3==value) at ROOT exit; r^3 uses full 12-bit width and r=0 always terminates.
REQ-017 If r >= 10, SHALL skip PAIR (no 3-bit pair reaches 100), set pair_found=0 and a_out=b_out=0, and go to DONE.
REQ-018 In PAIR, SHALL scan index k=0..63, one per cycle, with a=k[5:3] and b=k[2:0]; match is r^2 <= a^2+b^2 < (r+1)^2, evaluated at 7-bit width.
REQ-019 On the first match, SHALL latch pair_found=1, a_out=a, b_out=b and go to DONE; PAIR spends k_match+1 cycles.
REQ-020 If k=63 does not match, SHALL latch pair_found=0 and a_out=b_out=0 and go to DONE; PAIR spends 64 cycles.
REQ-021 In DONE, SHALL hold out_valid=1 until out_ready=1; on that edge it returns to IDLE and drops out_valid.
REQ-022 SHALL keep root/exact/pair_found/a_out/b_out stable while out_valid=1 and hold them unchanged in IDLE until the next ROOT exit.
REQ-023 SHALL make out_valid rise (16-r)+P cycles after the acceptance edge, where P is the PAIR cycle count (0 if skipped).
REQ-024 SHALL ignore in_valid outside IDLE; in_val changes after acceptance have no effect.
REQ-025 If out_ready is already high when DONE is entered, SHALL complete the handshake in that one cycle and raise in_ready on the next cycle.

Reset
REQ-026 On rst=1, SHALL force state IDLE, in_ready=1 on the following cycle, and out_valid=0, root=0, exact=0, pair_found=0, a_out=0, b_out=0.
REQ-027 SHALL let reset abort ROOT/PAIR/DONE mid-operation with no partial result and no out_valid pulse.
REQ-028 SHALL give reset priority over an acceptance or output handshake in the same cycle.

Structure
REQ-029 SHALL place the state enum and width constants (VAL_W=12, ROOT_W=4, OP_W=3) in shared package mode3_pkg.
REQ-030 SHALL use one combinational sub-module, mode3_cand_eval: inputs r, a, b, value; outputs cube_le (r^3 <= value), cube_eq and pair_match.

Verification
REQ-031 in_val=0 -> root=0, exact=1, pair_found=1, a=0, b=0; out_valid at 16+1=17 cycles.
REQ-032 in_val=125 -> root=5, exact=1, pair_found=1, a=0, b=5; out_valid at 11+6=17 cycles.
REQ-033 in_val=729 -> root=9, exact=1, pair_found=1, a=6, b=7 (k=55); out_valid at 7+56=63 cycles.
REQ-034 in_val=4095 -> root=15, exact=0, pair_found=0, a=b=0, PAIR skipped; out_valid at 1 cycle; with out_ready low for 5 cycles, outputs stay stable.
REQ-035 in_val=26 -> root=2, exact=0, a=0, b=2; out_valid at 14+3=17 cycles.
REQ-036 rst pulsed during PAIR for in_val=729 -> no out_valid, in_ready=1 next cycle, all outputs 0; a following in_val=125 gives REQ-032 results.
